// File: rtl/multimode_counter.sv
// Multi-mode synchronous counter: modulo-N up/down, ring, Johnson and hold,
// with parallel load, combinational terminal count and a registered wrap pulse.
module multimode_counter #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [1:0] MODE_MOD  = 2'b00;
  localparam logic [1:0] MODE_RING = 2'b01;
  localparam logic [1:0] MODE_JOHN = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] q_inv;
  logic             mod_valid, ring_valid, john_valid;
  logic             tc_c;

  // Per-mode legality of the current state; illegal states get corrected on the next count.
  always_comb begin
    q_inv      = ~q_q;
    mod_valid  = {1'b0, q_q} < MOD_EXT;
    ring_valid = (q_q != '0) && ((q_q & (q_q - LSB_ONE)) == '0);
    john_valid = ((q_q & (q_q + LSB_ONE)) == '0) ||
                 ((q_inv & (q_inv + LSB_ONE)) == '0);
  end

  // Terminal count: the state from which the next count step restarts the sequence.
  always_comb begin
    tc_c = 1'b0;
    case (mode)
      MODE_MOD:  tc_c = mod_valid  && (up ? (q_q == MOD_MAX) : (q_q == '0));
      MODE_RING: tc_c = ring_valid && (up ? (q_q == MSB_ONE) : (q_q == LSB_ONE));
      MODE_JOHN: tc_c = john_valid && (up ? (q_q == LSB_ONE) : (q_q == MSB_ONE));
      default:   tc_c = 1'b0;
    endcase
  end

  // Next state: load beats count; hold mode never counts.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = din;
    end else if (en && (mode != MODE_HOLD)) begin
      wrap_d = tc_c;
      case (mode)
        MODE_MOD: begin
          if (up) q_d = (!mod_valid || (q_q == MOD_MAX)) ? '0 : q_q + LSB_ONE;
          else    q_d = (!mod_valid || (q_q == '0)) ? MOD_MAX : q_q - LSB_ONE;
        end
        MODE_RING: begin
          if (!ring_valid) q_d = LSB_ONE;
          else if (up)     q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          else             q_d = {q_q[0], q_q[WIDTH-1:1]};
        end
        MODE_JOHN: begin
          if (!john_valid) q_d = '0;
          else if (up)     q_d = {~q_q[0], q_q[WIDTH-1:1]};
          else             q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_c;
  assign wrap = wrap_q;

endmodule
